matmul_result_sp: RTL and testbench
===================================

Name: matmul_result_sp

Overview:
- Result scratchpad directly downstream of the matmul calc stage.
- Captures the stream of C-element writes (enable/address/data), stores each completed result matrix in one of SP_NTARGETS targets, and latches the overflow flags on finish.
- Streams a selected stored matrix back to the calc stage as the C-bias operand.
- Serves a host read port for the result memory.

Parameters:
- DATA_WIDTH, 8, operand element width.
- BUS_WIDTH, 16, result element/bus width.
- ADDR_WIDTH, 32, address bus width.
- SP_NTARGETS, 4, number of result matrices held (power of 2, >=2).
- MAX_DIM (local), BUS_WIDTH/DATA_WIDTH, matrix dimension; ELEMS = MAX_DIM*MAX_DIM; IW = 2*clog2(MAX_DIM); TW = clog2(SP_NTARGETS).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin capture into target sp_target_i
- sp_target_i  in  TW  destination target, sampled on start_i
- enable_w_i  in  1  write strobe from calc stage
- address_i  in  ADDR_WIDTH  [4:0] operand code (5'b10000 = C), [5+IW-1:5] element index
- data_i  in  BUS_WIDTH  result element
- flags_i  in  BUS_WIDTH  overflow flags, valid with finish_mul_i
- finish_mul_i  in  1  calc-stage completion pulse
- bias_target_i  in  TW  target streamed as bias
- data_c_o  out  BUS_WIDTH  bias element for current bias index
- rd_en_i  in  1  host read request
- rd_addr_i  in  TW+IW  {target, element index}
- rd_data_o  out  BUS_WIDTH  host read data
- rd_valid_o  out  1  rd_data_o valid
- flags_o  out  BUS_WIDTH  flags of last committed result
- busy_o  out  1  capture in progress
- done_o  out  1  one-cycle commit pulse
- err_o  out  1  sticky protocol error
- incomplete_o  out  1  last commit had fewer than ELEMS unique writes

Behaviour:
- Reset (async, any time, including mid-capture): all storage words 0; FSM IDLE; bias index 0; all outputs 0. An in-flight capture is discarded.
- FSM IDLE:
  - start_i=1 -> COLLECT. Latch target, clear valid mask (ELEMS bits), err_o and incomplete_o.
  - Strobes and finish_mul_i in IDLE are ignored, but err_o sets.
- FSM COLLECT:
  - enable_w_i=1 with address_i[4:0]==5'b10000 writes data_i to sp[target][index] at the edge and sets the mask bit.
  - Rewriting the same index overwrites the word; mask is unchanged.
  - A strobe with any other operand code is dropped and sets err_o.
  - Address bits above the index field are ignored.
  - start_i while in COLLECT is ignored and sets err_o.
- finish_mul_i in COLLECT -> COMMIT. A strobe in the same cycle is still written.
- FSM COMMIT (one cycle):
  - flags_o <= flags_i as sampled with finish_mul_i.
  - incomplete_o <= (mask != all ones).
  - done_o=1 for exactly this cycle.
  - Next state IDLE. start_i in COMMIT is ignored, with no error.
- busy_o=1 in COLLECT and COMMIT.
- Bias stream:
  - Free-running bias index counter: 0..ELEMS-1, wraps to 0, increments every cycle from reset release.
  - data_c_o is a combinational mux = sp[bias_target_i][bias index], so it aligns with the calc stage's own reset-synchronous C-slot counter.
  - A write to the streamed word is visible on data_c_o the cycle after the write edge.
- Host read:
  - 1-cycle latency: rd_en_i at edge N -> rd_data_o = sp[rd_addr_i] and rd_valid_o=1 after edge N.
  - rd_valid_o=0 and rd_data_o holds when rd_en_i=0.
  - Read and write to the same word in the same cycle returns the old data.
- Widths: no arithmetic on data; stored as-is (signed two's complement, BUS_WIDTH). Index decode is exactly IW bits.

Test Plan (defaults, MAX_DIM=2, ELEMS=4):
- Full capture: start_i with target 2; write indices 0..3 with 16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000; finish_mul_i with flags 16'h0005 -> done_o pulse one cycle after finish; flags_o=16'h0005; incomplete_o=0; err_o=0. Host reads {2,0..3} return the four values, each one cycle after rd_en_i.
- Partial: capture into target 1 writing only indices 0 and 2, then finish -> incomplete_o=1; target 1 words 1 and 3 keep prior contents.
- Bias stream: with target 2 loaded as above, bias_target_i=2 -> data_c_o cycles 16'h0001, 16'hFFFE, 16'h7FFF, 16'h8000, repeating with period 4 aligned to reset release.
- Errors: write strobe with address_i[4:0]=5'b00100 during COLLECT -> word unchanged, err_o=1. Strobe in IDLE -> err_o=1. Next start_i clears err_o.
- Collision/reset: host read and write to {0,1} in the same cycle -> old value returned, new value on the next read. Assert rst_i mid-COLLECT -> busy_o=0, all storage 0, data_c_o=0 immediately (async).

Source files
------------

// File: rtl/matmul_result_sp.sv
// Result scratchpad after the matmul calc stage: captures C-element writes per target,
// streams a stored matrix back as the C bias and serves host reads.
module matmul_result_sp #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int SP_NTARGETS = 4,
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH,
    localparam int ELEMS   = MAX_DIM * MAX_DIM,
    localparam int IW      = 2 * $clog2(MAX_DIM),
    localparam int TW      = $clog2(SP_NTARGETS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [TW-1:0]         sp_target_i,
    input  logic                  enable_w_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic [BUS_WIDTH-1:0]  flags_i,
    input  logic                  finish_mul_i,
    input  logic [TW-1:0]         bias_target_i,
    output logic [BUS_WIDTH-1:0]  data_c_o,
    input  logic                  rd_en_i,
    input  logic [TW+IW-1:0]      rd_addr_i,
    output logic [BUS_WIDTH-1:0]  rd_data_o,
    output logic                  rd_valid_o,
    output logic [BUS_WIDTH-1:0]  flags_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  incomplete_o
);
    localparam int NWORDS = SP_NTARGETS * ELEMS;
    localparam logic [4:0] OP_C = 5'b10000;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          target_q, target_d;
    logic [ELEMS-1:0]       mask_q, mask_d;
    logic                   err_q, err_d;
    logic                   incomplete_q, incomplete_d;
    logic [BUS_WIDTH-1:0]   flags_q, flags_d;
    logic [IW-1:0]          bias_idx_q, bias_idx_d;
    logic [BUS_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [BUS_WIDTH-1:0]   mem_q [NWORDS];
    logic [BUS_WIDTH-1:0]   mem_d [NWORDS];

    logic [IW-1:0]          wr_idx;
    logic                   is_c;
    logic                   wr_en;
    logic                   unused_addr;

    assign wr_idx      = address_i[5 +: IW];
    assign is_c        = address_i[4:0] == OP_C;
    assign unused_addr = ^address_i[ADDR_WIDTH-1:5+IW];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_COLLECT;
            S_COLLECT: if (finish_mul_i) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = state_q != S_IDLE;
        done_o = state_q == S_COMMIT;
    end

    // Capture bookkeeping; commit status uses mask_d so a write on the finish cycle counts.
    always_comb begin
        target_d     = target_q;
        mask_d       = mask_q;
        err_d        = err_q;
        incomplete_d = incomplete_q;
        flags_d      = flags_q;
        wr_en        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    target_d     = sp_target_i;
                    mask_d       = '0;
                    err_d        = 1'b0;
                    incomplete_d = 1'b0;
                end else if (enable_w_i || finish_mul_i) begin
                    err_d = 1'b1;
                end
            end
            S_COLLECT: begin
                if (enable_w_i) begin
                    if (is_c) begin
                        wr_en          = 1'b1;
                        mask_d[wr_idx] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (start_i) err_d = 1'b1;
                if (finish_mul_i) begin
                    flags_d      = flags_i;
                    incomplete_d = ~&mask_d;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[{target_q, wr_idx}] = data_i;
    end

    always_comb begin
        bias_idx_d = bias_idx_q + 1'b1;
        rd_valid_d = rd_en_i;
        rd_data_d  = rd_en_i ? mem_q[rd_addr_i] : rd_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            target_q     <= '0;
            mask_q       <= '0;
            err_q        <= 1'b0;
            incomplete_q <= 1'b0;
            flags_q      <= '0;
            bias_idx_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            for (int i = 0; i < NWORDS; i++) mem_q[i] <= '0;
        end else begin
            target_q     <= target_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            incomplete_q <= incomplete_d;
            flags_q      <= flags_d;
            bias_idx_q   <= bias_idx_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            mem_q        <= mem_d;
        end
    end

    assign data_c_o     = mem_q[{bias_target_i, bias_idx_q}];
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign flags_o      = flags_q;
    assign err_o        = err_q;
    assign incomplete_o = incomplete_q;
endmodule

// File: tb/tb_matmul_result_sp.sv
// Directed bench for matmul_result_sp: capture, partial commit, bias stream,
// protocol errors, read/write collision and asynchronous reset.
module tb_matmul_result_sp;
    logic        clk, rst;
    logic        start_i, enable_w_i, finish_mul_i, rd_en_i;
    logic [1:0]  sp_target_i, bias_target_i;
    logic [31:0] address_i;
    logic [15:0] data_i, flags_i;
    logic [3:0]  rd_addr_i;
    logic [15:0] data_c_o, rd_data_o, flags_o;
    logic        rd_valid_o, busy_o, done_o, err_o, incomplete_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    logic [15:0] vals [4];

    matmul_result_sp dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .sp_target_i(sp_target_i),
        .enable_w_i(enable_w_i), .address_i(address_i), .data_i(data_i),
        .flags_i(flags_i), .finish_mul_i(finish_mul_i), .bias_target_i(bias_target_i),
        .data_c_o(data_c_o), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .flags_o(flags_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .incomplete_o(incomplete_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycles since reset release, i.e. the expected bias index position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap_start(input logic [1:0] t);
        start_i = 1'b1;
        sp_target_i = t;
        tick();
        start_i = 1'b0;
    endtask

    task automatic set_wr(input logic [1:0] idx, input logic [15:0] d,
                          input logic [4:0] code, input logic hi);
        enable_w_i = 1'b1;
        address_i = '0;
        address_i[4:0] = code;
        address_i[6:5] = idx;
        address_i[20] = hi;
        data_i = d;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [15:0] d, input logic [4:0] code);
        set_wr(idx, d, code, 1'b0);
        tick();
        enable_w_i = 1'b0;
    endtask

    task automatic fin(input logic [15:0] f);
        finish_mul_i = 1'b1;
        flags_i = f;
        tick();
        finish_mul_i = 1'b0;
        enable_w_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
        rd_en_i = 1'b1;
        rd_addr_i = a;
        tick();
        rd_en_i = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
        chk(tag, 32'(rd_data_o), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vals[0] = 16'h0001; vals[1] = 16'hFFFE;
        vals[2] = 16'h7FFF; vals[3] = 16'h8000;
        rst = 1'b1;
        start_i = 0; enable_w_i = 0; finish_mul_i = 0; rd_en_i = 0;
        sp_target_i = 0; bias_target_i = 2'd2; address_i = 0;
        data_i = 0; flags_i = 0; rd_addr_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_flags", 32'(flags_o), 0);
        chk("rst_valid", 32'(rd_valid_o), 0);
        chk("rst_bias", 32'(data_c_o), 0);
        rst = 1'b0;

        // full capture into target 2; last write shares the finish cycle
        cap_start(2'd2);
        chk("cap_busy", 32'(busy_o), 1);
        for (int i = 0; i < 3; i++) wr(2'(i), vals[i], 5'b10000);
        set_wr(2'd3, vals[3], 5'b10000, 1'b1);
        fin(16'h0005);
        chk("cap_done", 32'(done_o), 1);
        chk("cap_flags", 32'(flags_o), 32'h5);
        chk("cap_incomplete", 32'(incomplete_o), 0);
        chk("cap_err", 32'(err_o), 0);
        tick();
        chk("cap_done_low", 32'(done_o), 0);
        chk("cap_idle", 32'(busy_o), 0);
        for (int i = 0; i < 4; i++) rd_chk("cap_rd", 4'(8 + i), vals[i]);
        tick();
        chk("rd_idle_valid", 32'(rd_valid_o), 0);
        chk("rd_hold", 32'(rd_data_o), 32'h8000);

        // bias stream from target 2
        for (int k = 0; k < 8; k++) begin
            chk("bias", 32'(data_c_o), 32'(vals[cyc % 4]));
            tick();
        end

        // partial capture over a fully written target 1
        cap_start(2'd1);
        for (int i = 0; i < 4; i++) wr(2'(i), 16'hA000 + 16'(i), 5'b10000);
        fin(16'h0000);
        chk("pre_incomplete", 32'(incomplete_o), 0);
        tick();
        cap_start(2'd1);
        wr(2'd0, 16'h1234, 5'b10000);
        wr(2'd2, 16'h5678, 5'b10000);
        fin(16'h0009);
        chk("part_incomplete", 32'(incomplete_o), 1);
        chk("part_flags", 32'(flags_o), 32'h9);
        tick();
        rd_chk("part_rd0", 4'h4, 16'h1234);
        rd_chk("part_rd1", 4'h5, 16'hA001);
        rd_chk("part_rd2", 4'h6, 16'h5678);
        rd_chk("part_rd3", 4'h7, 16'hA003);

        // bad operand code
        cap_start(2'd3);
        chk("e1_clear", 32'(err_o), 0);
        wr(2'd1, 16'hBEEF, 5'b00100);
        chk("e1_badop", 32'(err_o), 1);
        fin(16'h0000);
        tick();
        chk("e1_sticky", 32'(err_o), 1);
        rd_chk("e1_word", 4'hD, 16'h0000);

        // start during collect
        cap_start(2'd3);
        chk("e2_clear", 32'(err_o), 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("e2_restart", 32'(err_o), 1);
        fin(16'h0000);
        tick();

        // start in commit is ignored; strobe in idle flags an error
        cap_start(2'd3);
        fin(16'h0000);
        start_i = 1'b1;
        sp_target_i = 2'd0;
        tick();
        start_i = 1'b0;
        chk("e3_commit_start_busy", 32'(busy_o), 0);
        chk("e3_commit_start_err", 32'(err_o), 0);
        wr(2'd0, 16'h4444, 5'b10000);
        chk("e3_idle_strobe", 32'(err_o), 1);
        rd_chk("e3_word", 4'hC, 16'h0000);
        cap_start(2'd3);
        chk("e3_clear", 32'(err_o), 0);
        fin(16'h0000);
        tick();

        // read/write collision on {0,1}, then async reset mid-capture
        bias_target_i = 2'd0;
        cap_start(2'd0);
        wr(2'd1, 16'h1111, 5'b10000);
        set_wr(2'd1, 16'h2222, 5'b10000, 1'b0);
        rd_en_i = 1'b1;
        rd_addr_i = 4'h1;
        tick();
        enable_w_i = 1'b0;
        rd_en_i = 1'b0;
        chk("coll_old", 32'(rd_data_o), 32'h1111);
        rd_chk("coll_new", 4'h1, 16'h2222);
        for (int k = 0; k < 4 && (cyc % 4) != 1; k++) tick();
        chk("coll_bias", 32'(data_c_o), 32'h2222);
        chk("coll_busy", 32'(busy_o), 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_bias", 32'(data_c_o), 0);
        chk("arst_rd", 32'(rd_data_o), 0);
        chk("arst_flags", 32'(flags_o), 0);
        tick();
        rst = 1'b0;
        rd_chk("arst_w01", 4'h1, 16'h0000);
        rd_chk("arst_w20", 4'h8, 16'h0000);
        chk("arst_idle", 32'(busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
